// File: rtl/phrase_pkg.sv
// Shared word/phrase geometry for the phrase-wide memory path (build_phrase / digest_phrase).
package phrase_pkg;

  localparam int WORD_WIDTH       = 16;
  localparam int WORDS_PER_PHRASE = 8;
  localparam int PHRASE_WIDTH     = WORD_WIDTH * WORDS_PER_PHRASE;

  typedef logic [PHRASE_WIDTH-1:0] phrase_t;
  typedef logic [WORD_WIDTH-1:0]   word_t;

endpackage

// File: rtl/build_phrase.sv
// Packs accepted words (first word in the LSBs) into phrases, with a one-phrase
// output register and a flush that emits a zero-padded partial phrase.
module build_phrase #(
  parameter int WORD_WIDTH       = phrase_pkg::WORD_WIDTH,
  parameter int WORDS_PER_PHRASE = phrase_pkg::WORDS_PER_PHRASE
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 valid_word,
  output logic                                 ready_word,
  input  logic [WORD_WIDTH-1:0]                word,
  input  logic                                 flush_in,
  output logic                                 valid_phrase,
  input  logic                                 ready_phrase,
  output logic [WORD_WIDTH*WORDS_PER_PHRASE-1:0] phrase_data,
  output logic [$clog2(WORDS_PER_PHRASE+1)-1:0]  phrase_words
);

  localparam int PW = WORD_WIDTH * WORDS_PER_PHRASE;
  localparam int CW = $clog2(WORDS_PER_PHRASE);
  localparam int NW = $clog2(WORDS_PER_PHRASE + 1);

  // Handshakes: a word moves when valid_word && ready_word, a phrase when
  // valid_phrase && ready_phrase; valid is never withdrawn without a transfer.

  logic [PW-1:0] acc;
  logic [PW-1:0] acc_next;
  logic [CW-1:0] cnt;
  logic          flush_pending;

  logic          out_free;
  logic          last;
  logic          accept;
  logic          complete;
  logic          flush_req;
  logic          load;
  logic [NW-1:0] total;

  assign out_free   = !valid_phrase || ready_phrase;
  assign last       = (cnt == CW'(WORDS_PER_PHRASE - 1));
  assign ready_word = rst_in && !flush_pending && (!last || out_free);
  assign accept     = valid_word && ready_word;
  assign complete   = accept && last;
  assign total      = NW'(cnt) + NW'(accept);
  assign flush_req  = (flush_in || flush_pending) && (total != '0);
  // A completing word only gets in when out_free, so completion always loads.
  assign load       = complete || (flush_req && out_free);

  always_comb begin
    acc_next = acc;
    if (accept) acc_next[cnt*WORD_WIDTH +: WORD_WIDTH] = word;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      acc           <= '0;
      cnt           <= '0;
      flush_pending <= 1'b0;
      valid_phrase  <= 1'b0;
      phrase_data   <= '0;
      phrase_words  <= '0;
    end else begin
      if (valid_phrase && ready_phrase) valid_phrase <= 1'b0;
      if (load) begin
        phrase_data   <= acc_next;
        phrase_words  <= total;
        valid_phrase  <= 1'b1;
        acc           <= '0;
        cnt           <= '0;
        flush_pending <= 1'b0;
      end else begin
        if (accept) begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
        end
        // Stays set only while a non-empty partial waits for the output register.
        flush_pending <= flush_req;
      end
    end
  end

endmodule

// File: tb/tb_build_phrase.sv
// Bench for build_phrase: directed vector table plus hand-written backpressure,
// flush-pending and mid-phrase reset sequences checked against a queue model.
module tb_build_phrase;
  import phrase_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       valid_word = 1'b0;
  logic       ready_word;
  word_t      word = '0;
  logic       flush_in = 1'b0;
  logic       valid_phrase;
  logic       ready_phrase = 1'b0;
  phrase_t    phrase_data;
  logic [3:0] phrase_words;

  build_phrase dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .valid_word   (valid_word),
    .ready_word   (ready_word),
    .word         (word),
    .flush_in     (flush_in),
    .valid_phrase (valid_phrase),
    .ready_phrase (ready_phrase),
    .phrase_data  (phrase_data),
    .phrase_words (phrase_words)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  logic [PHRASE_WIDTH-1:0] exp_q[$];
  logic [3:0]              exp_w_q[$];
  phrase_t                 m_acc = '0;
  int                      m_cnt = 0;
  bit                      sb_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: a phrase transfer is predicted at the negedge before the edge that takes it.
  always @(negedge clk_in) begin
    if (sb_en && rst_in && valid_phrase && ready_phrase) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%h required=none", phrase_data);
      end else begin
        check("sb_data", phrase_data, exp_q.pop_front());
        check("sb_words", 128'(phrase_words), 128'(exp_w_q.pop_front()));
      end
    end
  end

  // One clock cycle: drive at posedge+1, sample ready_word, return at next posedge+1.
  task automatic cycle(input bit vw, input word_t w, input bit fl, input bit rp, output bit accepted);
    valid_word   = vw;
    word         = w;
    flush_in     = fl;
    ready_phrase = rp;
    #1;
    accepted = vw && ready_word;
    if (accepted) begin
      m_acc[m_cnt*16 +: 16] = w;
      m_cnt++;
      if (m_cnt == 8) begin
        exp_q.push_back(m_acc);
        exp_w_q.push_back(4'd8);
        m_acc = '0;
        m_cnt = 0;
      end
    end
    if (fl && m_cnt > 0) begin
      exp_q.push_back(m_acc);
      exp_w_q.push_back(4'(m_cnt));
      m_acc = '0;
      m_cnt = 0;
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic drain(input string name);
    bit a;
    for (int n = 0; n < 30 && exp_q.size() > 0; n++) cycle(1'b0, '0, 1'b0, 1'b1, a);
    cycle(1'b0, '0, 1'b0, 1'b1, a);
    check(name, 128'(exp_q.size()), 128'(0));
  endtask

  typedef struct {
    bit         vw;
    word_t      w;
    bit         fl;
    bit         rp;
    bit         e_rw;
    bit         e_vp;
    logic [3:0] e_pw;
    phrase_t    e_pd;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input bit vw, input word_t w, input bit fl, input bit e_rw,
                         input bit e_vp, input logic [3:0] e_pw, input phrase_t e_pd);
    vec_t v;
    v.vw = vw; v.w = w; v.fl = fl; v.rp = 1'b1;
    v.e_rw = e_rw; v.e_vp = e_vp; v.e_pw = e_pw; v.e_pd = e_pd;
    vq.push_back(v);
  endtask

  bit a;
  int acc_cnt;
  phrase_t p1, p2, p3;

  initial begin
    p1 = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    p2 = 128'hCCCC_BBBB_AAAA;
    p3 = 128'h2222_1111;

    for (int i = 0; i < 7; i++) add_vec(1'b1, word_t'(i + 1), 1'b0, 1'b1, 1'b0, 4'd0, '0);
    add_vec(1'b1, 16'h0008, 1'b0, 1'b1, 1'b1, 4'd8, p1);
    add_vec(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd8, p1);
    add_vec(1'b1, 16'hAAAA, 1'b0, 1'b1, 1'b0, 4'd8, p1);
    add_vec(1'b1, 16'hBBBB, 1'b0, 1'b1, 1'b0, 4'd8, p1);
    add_vec(1'b1, 16'hCCCC, 1'b0, 1'b1, 1'b0, 4'd8, p1);
    add_vec(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'd3, p2);
    add_vec(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd3, p2);
    add_vec(1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, 4'd3, p2);
    add_vec(1'b1, 16'h2222, 1'b1, 1'b1, 1'b1, 4'd2, p3);
    add_vec(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd2, p3);

    // Reset values
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_valid_phrase", 128'(valid_phrase), 128'(0));
    check("rst_phrase_data", phrase_data, '0);
    check("rst_phrase_words", 128'(phrase_words), 128'(0));
    check("rst_ready_word", 128'(ready_word), 128'(0));
    rst_in = 1'b1;

    // Vector table: ready_word checked before the edge, outputs after it
    for (int i = 0; i < vq.size(); i++) begin
      valid_word   = vq[i].vw;
      word         = vq[i].w;
      flush_in     = vq[i].fl;
      ready_phrase = vq[i].rp;
      #1;
      check($sformatf("vec%0d_ready_word", i), 128'(ready_word), 128'(vq[i].e_rw));
      @(posedge clk_in);
      #1;
      check($sformatf("vec%0d_valid_phrase", i), 128'(valid_phrase), 128'(vq[i].e_vp));
      check($sformatf("vec%0d_phrase_words", i), 128'(phrase_words), 128'(vq[i].e_pw));
      check($sformatf("vec%0d_phrase_data", i), phrase_data, vq[i].e_pd);
    end

    sb_en = 1'b1;

    // 24 continuous words, ready_phrase high: no intake bubbles
    for (int i = 0; i < 24; i++) begin
      cycle(1'b1, word_t'($urandom_range(0, 65535)), 1'b0, 1'b1, a);
      check($sformatf("stream_ready_word%0d", i), 128'(a), 128'(1));
    end
    drain("stream_drain");

    // Backpressure: 15 words of capacity, held phrase stable
    acc_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, word_t'(16'h1000 + i), 1'b0, 1'b0, a);
      if (a) acc_cnt++;
      if (i >= 8) begin
        check("bp_valid_phrase", 128'(valid_phrase), 128'(1));
        check("bp_hold_data", phrase_data, exp_q[0]);
      end
    end
    check("bp_accept_count", 128'(acc_cnt), 128'(15));
    check("bp_ready_word_low", 128'(ready_word), 128'(0));
    cycle(1'b1, 16'h2000, 1'b0, 1'b1, a);
    check("bp_ready_restored", 128'(a), 128'(1));
    drain("bp_drain");

    // Flush while the output register is occupied
    for (int i = 0; i < 8; i++) cycle(1'b1, word_t'(16'h3000 + i), 1'b0, 1'b0, a);
    cycle(1'b1, 16'h3100, 1'b0, 1'b0, a);
    cycle(1'b1, 16'h3101, 1'b1, 1'b0, a);
    check("fp_flush_pending", 128'(dut.flush_pending), 128'(1));
    check("fp_ready_word", 128'(ready_word), 128'(0));
    cycle(1'b1, 16'h3200, 1'b0, 1'b0, a);
    check("fp_stall", 128'(a), 128'(0));
    cycle(1'b0, '0, 1'b0, 1'b1, a);
    check("fp_follow_valid", 128'(valid_phrase), 128'(1));
    check("fp_follow_words", 128'(phrase_words), 128'(2));
    check("fp_pending_clear", 128'(dut.flush_pending), 128'(0));
    drain("fp_drain");

    // Asynchronous reset with a held phrase and a partial in flight
    for (int i = 0; i < 8; i++) cycle(1'b1, word_t'(16'h4000 + i), 1'b0, 1'b0, a);
    for (int i = 0; i < 5; i++) cycle(1'b1, word_t'(16'h4100 + i), 1'b0, 1'b0, a);
    valid_word = 1'b0;
    #2;
    rst_in = 1'b0;
    #1;
    check("ar_valid_phrase", 128'(valid_phrase), 128'(0));
    check("ar_phrase_data", phrase_data, '0);
    check("ar_phrase_words", 128'(phrase_words), 128'(0));
    check("ar_ready_word", 128'(ready_word), 128'(0));
    exp_q.delete();
    exp_w_q.delete();
    m_acc = '0;
    m_cnt = 0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1'b1, word_t'(16'h5000 + i), 1'b0, 1'b1, a);
    drain("ar_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/build_phrase.md
# build_phrase

Packs a stream of 16-bit words into 128-bit phrases. It is the write-side counterpart of `digest_phrase` and sits between the camera pixel path and the phrase-wide memory/FIFO interface. Each phrase is built from eight consecutive accepted words. A registered output stage lets word intake continue at one word per cycle while a finished phrase waits for its consumer. A flush input emits a partially filled, zero-padded phrase at frame/line end.

## Interface
Parameters:
- `WORD_WIDTH`, 16: width of one input word.
- `WORDS_PER_PHRASE`, 8: words per phrase; phrase width is the product of the two (128).

Ports:
- `clk_in`  input  1  single clock for all logic.
- `rst_in`  input  1  reset, asynchronous assertion, active-low.
- `valid_word`  input  1  `word` carries valid data.
- `ready_word`  output  1  block accepts `word` this cycle.
- `word`  input  16  input word.
- `flush_in`  input  1  single-cycle request to emit the current partial phrase.
- `valid_phrase`  output  1  `phrase_data` is valid.
- `ready_phrase`  input  1  consumer takes the phrase this cycle.
- `phrase_data`  output  128  assembled phrase.
- `phrase_words`  output  4  count of valid words in `phrase_data`, 1..8.

## Operation
- Accumulator: shift/index register `acc`, count `cnt` 0..7, output register `out` with `valid_phrase`, flag `flush_pending`.
- A word is accepted when `valid_word && ready_word`. Word k of a phrase (k = 0..7) lands in bits [16k+15:16k], so the first word occupies the LSBs.
- Output transfer occurs when `valid_phrase && ready_phrase`; `valid_phrase` then drops unless a new phrase loads on the same edge.
- `out_free = !valid_phrase || ready_phrase`.
- `ready_word = rst_in && !flush_pending && (cnt != 7 || out_free)`. This is combinational from `ready_phrase`.
- Completion: accepting a word with `cnt == 7` loads the full phrase into `out` with `phrase_words = 8`, sets `valid_phrase`, clears `acc` to 0, and sets `cnt` to 0.
- Flush:
  - A flush is effective when `flush_in` or `flush_pending` is high and the resulting count (`cnt` plus any word accepted this cycle) is greater than 0.
  - If `out_free`, the padded phrase loads into `out` with `phrase_words` set to that count, and `acc`/`cnt` clear.
  - Otherwise `flush_pending` is set and intake stalls until the load happens.
- A word accepted on the same cycle as a flush is included in the flushed phrase.
- If that word completes a phrase (`cnt == 7`), the flush is consumed by the normal completion and nothing extra is emitted.
- `flush_in` with count 0 and no pending phrase is ignored.
- Unused upper bits of a flushed phrase are 0.
- `phrase_data` and `phrase_words` are held stable while `valid_phrase && !ready_phrase`.

## Timing
- Reset (`rst_in` low, asynchronous):
  - `valid_phrase` = 0, `phrase_data` = 0, `phrase_words` = 0, `cnt` = 0, `acc` = 0, `flush_pending` = 0.
  - `ready_word` = 0 while in reset and 1 in the first cycle after release.
- Latency: `valid_phrase` rises on the clock edge that accepts the 8th word, so it is visible the following cycle.
- Throughput: sustained 1 word/cycle with `ready_phrase` held high, giving one phrase every 8 cycles with no bubbles.
- Backpressure capacity is 15 words: one full phrase in `out` plus 7 in `acc`. The 16th word stalls until `ready_phrase`.
- `valid_phrase` never drops without a transfer. `ready_phrase` may be asserted before or after `valid_phrase`.
- Reset asserted mid-phrase discards both partial and held data with no output.

## Structure
- Package `phrase_pkg`:
  - `WORD_WIDTH` and `WORDS_PER_PHRASE` localparams, shared with `digest_phrase`.
  - `phrase_t` (logic [127:0]) and `word_t` (logic [15:0]) typedefs.
- Single module; no sub-module. The output register stage is small enough to stay inline.

## Test plan
- Reset release, then words 0x0001..0x0008 back-to-back with `ready_phrase` = 1:
  - `phrase_data` = 0x0008_0007_0006_0005_0004_0003_0002_0001 and `phrase_words` = 8.
  - `valid_phrase` is high for exactly 1 cycle, the cycle after the 8th accept.
- 24 continuous words with `ready_phrase` = 1: 3 phrases, `ready_word` never drops.
- `ready_phrase` = 0 with `valid_word` held high:
  - Exactly 15 words are accepted, then `ready_word` = 0 and the first phrase is held stable.
  - Raising `ready_phrase` for 1 cycle restores `ready_word` in that same cycle.
- 3 words 0xAAAA, 0xBBBB, 0xCCCC, then `flush_in`:
  - Phrase 0x…0000_CCCC_BBBB_AAAA with upper bits 0 and `phrase_words` = 3.
  - A second `flush_in` with empty `acc` emits nothing.
- Flush while `out` is occupied and `ready_phrase` = 0:
  - `flush_pending` is set and `ready_word` = 0.
  - After `ready_phrase` rises, the partial phrase follows the held phrase on the next cycle.
- `rst_in` pulsed low asynchronously after 5 words: all outputs go to 0 immediately, and the next 8 words form a clean phrase with no stale data.
